control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter EXEC_TIMEOUT, default 16, max cycles spent in EXEC waiting for alu_done before abort.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr  input  32  instruction word from fetch.
REQ-005 instr_valid  input  1  instr is valid this cycle.
REQ-006 instr_ready  output  1  block accepts instr this cycle.
REQ-007 opcode  output  6  registered instr[31:26] for the register file.
REQ-008 reg1, reg2, reg3  output  5 each  registered instr[25:21], instr[20:16], instr[15:11].
REQ-009 imm  output  32  extended immediate.
REQ-010 reg_read, reg_write  output  1 each  register-file control pulses, never both high.
REQ-011 alu_start  output  1  one-cycle pulse launching execute.
REQ-012 alu_done  input  1  execute result valid.
REQ-013 busy  output  1  high in any state except IDLE.
REQ-014 timeout  output  1  one-cycle pulse on EXEC abort.

Function
REQ-015 FSM states IDLE, DECODE, READ, EXEC, WB; one state per cycle except EXEC.
REQ-016 IDLE: instr_ready=1; instr_valid&instr_ready captures instr into opcode/reg1-3/imm; go DECODE.
REQ-017 DECODE: imm computed; go READ.
REQ-018 READ: reg_read=1 for exactly one cycle; go EXEC.
REQ-019 EXEC entry: alu_start=1 on first EXEC cycle only; stay until alu_done=1.
REQ-020 EXEC: alu_done=1 with writeback class -> WB; without writeback class -> IDLE.
REQ-021 Writeback suppressed for opcode[5:1]==5'b01111 (BEQ/BLT) and opcode==6'b011011 (SW).
REQ-022 WB: reg_write=1 for exactly one cycle; opcode/reg1 held stable; go IDLE.
REQ-023 imm: opcode[5:1]==5'b01000 (LDI/LUI) zero-extends instr[15:0]; all others sign-extend instr[15:0].
REQ-024 EXEC cycle counter: cleared on EXEC entry; counter reaching EXEC_TIMEOUT without alu_done -> timeout=1, go IDLE, no reg_write.
REQ-025 alu_done on the same cycle the counter hits EXEC_TIMEOUT: done wins, no timeout.
REQ-026 alu_done outside EXEC ignored; instr_valid outside IDLE ignored (instr_ready=0).
REQ-027 Latency: accept to reg_write = 4 cycles when alu_done returns on the first EXEC cycle.
REQ-028 Back-to-back: IDLE re-entered after WB accepts the next instr on that cycle.

Reset
REQ-029 reset overrides all inputs, including mid-operation in any state: next state IDLE.
REQ-030 Reset values: opcode=0, reg1-3=0, imm=0, reg_read=0, reg_write=0, alu_start=0, timeout=0, busy=0, instr_ready=1 after reset deasserts.

Configuration
REQ-031 Macro CTRL_ILLEGAL_OP_EN: when defined, an output illegal_op (1 bit) pulses in DECODE for opcode[5]==1 and the FSM returns to IDLE with no reg_read/reg_write.
REQ-032 Without CTRL_ILLEGAL_OP_EN: port illegal_op absent; opcode[5]==1 executes as a normal writeback instruction.

Structure
REQ-033 Package ctrl_pkg holds opcode constants (LDI, LUI, LB, BEQ, BLT, SW), state enumeration, instruction field bit positions.
REQ-034 Sub-module imm_extend: combinational, opcode+instr[15:0] in, 32-bit imm out.

Verification
REQ-035 Reset, then instr=ADD r3,r1,r2 (opcode 000000), alu_done on 1st EXEC cycle -> reg_read at cycle+2, alu_start cycle+3, reg_write cycle+4, reg1=3.
REQ-036 LDI r5, imm16=0x8001 -> imm=0x00008001; ADDI imm16=0x8001 -> imm=0xFFFF8001.
REQ-037 BEQ (opcode 011110) with alu_done -> return to IDLE, reg_write never asserted.
REQ-038 EXEC_TIMEOUT=16, alu_done held low -> timeout pulse on 16th EXEC cycle, IDLE next, no reg_write; alu_done on that cycle instead -> WB, no timeout.
REQ-039 reset asserted in EXEC and in WB -> IDLE next cycle, all outputs at reset values, instr_ready=1.
REQ-040 With CTRL_ILLEGAL_OP_EN, opcode 100000 -> illegal_op pulse in DECODE, no reg_read; without the macro, the same opcode completes with reg_write.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module      : ctrl_pkg
// Description : Opcode constants, FSM state encoding and instruction field
//               positions shared by control_unit and imm_extend.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

   localparam logic [5:0] OP_LDI = 6'b010000;
   localparam logic [5:0] OP_LUI = 6'b010001;
   localparam logic [5:0] OP_LB  = 6'b011010;
   localparam logic [5:0] OP_SW  = 6'b011011;
   localparam logic [5:0] OP_BEQ = 6'b011110;
   localparam logic [5:0] OP_BLT = 6'b011111;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 26;
   localparam int R1_MSB  = 25;
   localparam int R1_LSB  = 21;
   localparam int R2_MSB  = 20;
   localparam int R2_LSB  = 16;
   localparam int R3_MSB  = 15;
   localparam int R3_LSB  = 11;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECODE = 3'd1,
      ST_READ   = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4
   } state_t;

   // Branches (BEQ/BLT share opcode[5:1]) and stores produce no register result.
   function automatic logic has_writeback(input logic [5:0] op);
      return !((op[5:1] == OP_BEQ[5:1]) || (op == OP_SW));
   endfunction

endpackage

`default_nettype wire

// File: rtl/imm_extend.sv
// ============================================================================
// Module      : imm_extend
// Description : Combinational immediate extension; LDI/LUI zero-extend,
//               every other opcode sign-extends the 16-bit field.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_extend
   import ctrl_pkg::*;
(
   input  logic [5:0]  opcode,
   input  logic [15:0] imm16,
   output logic [31:0] imm
);

   always_comb begin
      if (opcode[5:1] == OP_LDI[5:1]) begin
         imm = {16'h0000, imm16};
      end else begin
         imm = {{16{imm16[15]}}, imm16};
      end
   end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module      : control_unit
// Description : IDLE/DECODE/READ/EXEC/WB instruction sequencer with EXEC
//               timeout. Optional macro CTRL_ILLEGAL_OP_EN adds illegal_op.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit
   import ctrl_pkg::*;
#(
   parameter int EXEC_TIMEOUT = 16
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   output logic [5:0]  opcode,
   output logic [4:0]  reg1,
   output logic [4:0]  reg2,
   output logic [4:0]  reg3,
   output logic [31:0] imm,
   output logic        reg_read,
   output logic        reg_write,
   output logic        alu_start,
   input  logic        alu_done,
   output logic        busy,
   output logic        timeout
`ifdef CTRL_ILLEGAL_OP_EN
   ,
   output logic        illegal_op
`endif
);

   localparam int CNT_W = $clog2(EXEC_TIMEOUT + 1);
   localparam int LAST  = EXEC_TIMEOUT - 1;

   state_t             state;
   state_t             next_state;
   logic [CNT_W-1:0]   exec_cnt;
   logic               capture;
   logic [31:0]        imm_ext;

   imm_extend u_imm_extend (
      .opcode (instr[OPC_MSB:OPC_LSB]),
      .imm16  (instr[IMM_MSB:IMM_LSB]),
      .imm    (imm_ext)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         opcode   <= '0;
         reg1     <= '0;
         reg2     <= '0;
         reg3     <= '0;
         imm      <= '0;
         exec_cnt <= '0;
      end else begin
         state <= next_state;
         if (capture) begin
            opcode <= instr[OPC_MSB:OPC_LSB];
            reg1   <= instr[R1_MSB:R1_LSB];
            reg2   <= instr[R2_MSB:R2_LSB];
            reg3   <= instr[R3_MSB:R3_LSB];
            imm    <= imm_ext;
         end
         // Counter idles at zero outside EXEC, so it is already clear on entry.
         if (state != ST_EXEC) begin
            exec_cnt <= '0;
         end else if (exec_cnt != CNT_W'(LAST)) begin
            exec_cnt <= exec_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      next_state  = state;
      capture     = 1'b0;
      instr_ready = 1'b0;
      reg_read    = 1'b0;
      reg_write   = 1'b0;
      alu_start   = 1'b0;
      timeout     = 1'b0;
`ifdef CTRL_ILLEGAL_OP_EN
      illegal_op  = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               capture    = 1'b1;
               next_state = ST_DECODE;
            end
         end
         ST_DECODE: begin
`ifdef CTRL_ILLEGAL_OP_EN
            if (opcode[5]) begin
               illegal_op = 1'b1;
               next_state = ST_IDLE;
            end else begin
               next_state = ST_READ;
            end
`else
            next_state = ST_READ;
`endif
         end
         ST_READ: begin
            reg_read   = 1'b1;
            next_state = ST_EXEC;
         end
         ST_EXEC: begin
            alu_start = (exec_cnt == '0);
            // A done arriving on the final allowed cycle takes priority over abort.
            if (alu_done) begin
               next_state = has_writeback(opcode) ? ST_WB : ST_IDLE;
            end else if (exec_cnt == CNT_W'(LAST)) begin
               timeout    = 1'b1;
               next_state = ST_IDLE;
            end
         end
         ST_WB: begin
            reg_write  = 1'b1;
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   assign busy = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module      : tb_control_unit
// Description : Randomized bench for control_unit against a cycle-offset
//               transaction model, plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

   localparam int TO = 16;
`ifdef CTRL_ILLEGAL_OP_EN
   localparam bit ILL = 1'b1;
`else
   localparam bit ILL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [5:0]  opcode;
   logic [4:0]  reg1, reg2, reg3;
   logic [31:0] imm;
   logic        reg_read, reg_write, alu_start, alu_done, busy, timeout;
`ifdef CTRL_ILLEGAL_OP_EN
   logic        illegal_op;
`endif

   always #5 clk = ~clk;

   control_unit #(.EXEC_TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .opcode      (opcode),
      .reg1        (reg1),
      .reg2        (reg2),
      .reg3        (reg3),
      .imm         (imm),
      .reg_read    (reg_read),
      .reg_write   (reg_write),
      .alu_start   (alu_start),
      .alu_done    (alu_done),
      .busy        (busy),
      .timeout     (timeout)
`ifdef CTRL_ILLEGAL_OP_EN
      ,
      .illegal_op  (illegal_op)
`endif
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model: a transaction accepted at cycle m_acc is DECODE at +1, READ at +2,
   // EXEC from +3 until done/abort; m_wb marks the single write-back cycle.
   bit          m_idle;
   bit          m_wb;
   int          m_acc;
   logic [5:0]  m_op;
   logic [4:0]  m_r1, m_r2, m_r3;
   logic [31:0] m_imm;

   logic        s_ready, s_busy, s_read, s_write, s_start, s_to;
   logic [5:0]  s_op;
   logic [4:0]  s_r1;
   logic [31:0] s_imm;

   logic [5:0]  ops [8] = '{6'b000000, 6'b001000, 6'b010000, 6'b010001,
                            6'b011010, 6'b011110, 6'b011111, 6'b011011};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic bit writes_back(input logic [5:0] op);
      return !(op[5:1] == 5'b01111 || op == 6'b011011);
   endfunction

   function automatic logic [31:0] ext_imm(input logic [5:0] op, input logic [15:0] v);
      int s;
      s = int'(v);
      if (op[5:1] != 5'b01000 && s >= 32768) s = s - 65536;
      return 32'(s);
   endfunction

   task automatic model_reset();
      m_idle = 1'b1; m_wb = 1'b0;
      m_op = '0; m_r1 = '0; m_r2 = '0; m_r3 = '0; m_imm = '0;
   endtask

   task automatic compare();
      int k;
      bit ex;
      k  = cyc - m_acc;
      ex = !m_idle && !m_wb && k >= 3;
      s_ready = instr_ready; s_busy = busy; s_read = reg_read; s_write = reg_write;
      s_start = alu_start; s_to = timeout; s_op = opcode; s_r1 = reg1; s_imm = imm;
      chk("instr_ready", instr_ready, m_idle);
      chk("busy", busy, !m_idle);
      chk("reg_read", reg_read, !m_idle && k == 2);
      chk("alu_start", alu_start, ex && k == 3);
      chk("reg_write", reg_write, m_wb);
      chk("timeout", timeout, ex && (k - 2) == TO && !alu_done);
      chk("opcode", opcode, m_op);
      chk("reg1", reg1, m_r1);
      chk("reg2", reg2, m_r2);
      chk("reg3", reg3, m_r3);
      chk("imm", imm, m_imm);
`ifdef CTRL_ILLEGAL_OP_EN
      chk("illegal_op", illegal_op, !m_idle && k == 1 && m_op[5]);
`endif
   endtask

   task automatic update();
      int k;
      k = cyc - m_acc;
      if (reset) begin
         model_reset();
      end else if (m_idle) begin
         if (instr_valid) begin
            m_idle = 1'b0; m_acc = cyc;
            m_op = instr[31:26]; m_r1 = instr[25:21]; m_r2 = instr[20:16];
            m_r3 = instr[15:11]; m_imm = ext_imm(instr[31:26], instr[15:0]);
         end
      end else if (m_wb) begin
         m_wb = 1'b0; m_idle = 1'b1;
      end else if (k == 1 && ILL && m_op[5]) begin
         m_idle = 1'b1;
      end else if (k >= 3) begin
         if (alu_done) begin
            if (writes_back(m_op)) m_wb = 1'b1;
            else m_idle = 1'b1;
         end else if (k - 2 == TO) begin
            m_idle = 1'b1;
         end
      end
      cyc++;
   endtask

   task automatic step(input bit r, input bit v, input logic [31:0] ins, input bit d);
      @(negedge clk);
      reset = r; instr_valid = v; instr = ins; alu_done = d;
      #1;
      compare();
      @(posedge clk);
      update();
   endtask

   // Accept, decode, read, then `ndelay` idle EXEC cycles before done.
   task automatic issue(input logic [31:0] ins, input int ndelay,
                        output logic [31:0] dec_imm, output bit wrote, output bit to_at_done);
      step(0, 1, ins, 0);
      step(0, 0, 0, 0); dec_imm = s_imm;
      step(0, 0, 0, 0);
      for (int i = 0; i < ndelay; i++) step(0, 0, 0, 0);
      step(0, 0, 0, 1); to_at_done = s_to;
      step(0, 0, 0, 0); wrote = s_write;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ins, dimm, add;
      bit          wr, tod, r, v, d;
      int          pdone;

      reset = 1'b1; instr_valid = 1'b0; instr = '0; alu_done = 1'b0;
      @(posedge clk);
      model_reset();
      cyc = 1;

      // Reset state
      step(0, 0, 0, 0);
      chk("rst_ready", s_ready, 1); chk("rst_busy", s_busy, 0);
      chk("rst_opcode", s_op, 0);   chk("rst_imm", s_imm, 0);

      // ADD r3,r1,r2 latency
      add = {6'b000000, 5'd3, 5'd1, 5'd2, 11'd0};
      step(0, 1, add, 0); chk("add_accept_ready", s_ready, 1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0); chk("add_read_c2", s_read, 1);
      step(0, 0, 0, 1); chk("add_start_c3", s_start, 1); chk("add_nowrite_c3", s_write, 0);
      step(0, 0, 0, 0); chk("add_write_c4", s_write, 1); chk("add_reg1", s_r1, 3);

      // Immediate extension
      issue({6'b010000, 5'd5, 5'd0, 16'h8001}, 0, dimm, wr, tod);
      chk("ldi_imm", dimm, 32'h0000_8001); chk("ldi_write", wr, 1);
      issue({6'b001000, 5'd1, 5'd2, 16'h8001}, 0, dimm, wr, tod);
      chk("addi_imm", dimm, 32'hFFFF_8001);

      // BEQ: no write-back
      issue({6'b011110, 5'd1, 5'd2, 16'h0004}, 0, dimm, wr, tod);
      chk("beq_nowrite", wr, 0); chk("beq_idle", s_ready, 1);

      // Timeout on 16th EXEC cycle
      step(0, 1, add, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0);
      chk("to_not_early", s_to, 0);
      step(0, 0, 0, 0); chk("to_pulse", s_to, 1);
      step(0, 0, 0, 0); chk("to_idle", s_ready, 1); chk("to_nowrite", s_write, 0);

      // Done on the 16th EXEC cycle wins
      issue(add, TO - 1, dimm, wr, tod);
      chk("done_wins_to", tod, 0); chk("done_wins_wb", wr, 1);

      // Reset in EXEC
      step(0, 1, add, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("rexec_busy", s_busy, 0); chk("rexec_ready", s_ready, 1);
      chk("rexec_opcode", s_op, 0); chk("rexec_reg1", s_r1, 0);

      // Reset in WB
      step(0, 1, {6'b000001, 5'd9, 5'd4, 16'h7777}, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      step(1, 0, 0, 0); chk("rwb_in_wb", s_write, 1);
      step(0, 0, 0, 0);
      chk("rwb_busy", s_busy, 0); chk("rwb_ready", s_ready, 1);
      chk("rwb_imm", s_imm, 0); chk("rwb_write", s_write, 0);

      // opcode[5] set
      issue({6'b100000, 5'd7, 5'd1, 16'h0001}, 0, dimm, wr, tod);
      chk("op100000_write", wr, !ILL);

      // Randomized traffic
      for (int seg = 0; seg < 20; seg++) begin
         pdone = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 10 : 60);
         for (int i = 0; i < 150; i++) begin
            r   = ($urandom_range(99) < 2);
            v   = $urandom_range(1);
            ins = $urandom;
            if ($urandom_range(3) != 0) ins[31:26] = ops[$urandom_range(7)];
            d   = ($urandom_range(99) < pdone);
            step(r, v, ins, d);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
